hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard and forwarding unit for the 5-stage MIPS core.
- Consumes the pipelined control bits from the controller (regwrite/memtoreg per stage, branch, jump, pcsrc) and register specifiers from the datapath.
- Returns stalls, flushes (including flushE back to the controller) and forwarding selects.
- Adds a sequential data-memory wait FSM with timeout and a saturating stall-cycle counter.

Parameters:
- TIMEOUT, 16, max cycles in WAIT before entering ERR; legal range 2..255.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rsD, rtD  in  5  decode-stage source registers.
- rsE, rtE  in  5  execute-stage source registers.
- writeregE, writeregM, writeregW  in  5  destination register in each stage.
- regwriteE, regwriteM, regwriteW  in  1  register-write enables per stage.
- memtoregE, memtoregM  in  1  load-in-stage flags.
- branchD, jumpD, pcsrcD  in  1  decode branch, jump, and taken-branch.
- memreqM  in  1  M stage is accessing dmem (load or store).
- dmem_ready  in  1  dmem completes access this cycle.
- stallF, stallD, stallE, stallM  out  1  hold the corresponding pipeline register.
- flushD, flushE, flushW  out  1  clear the corresponding pipeline register.
- forwardAD, forwardBD  out  1  decode compare operand from the M-stage ALU result.
- forwardAE, forwardBE  out  2  00 register file, 01 W result, 10 M ALU result.
- dmem_err  out  1  sticky timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with stallF high.

Behaviour:
- Forwarding (combinational):
  - forwardAE = 10 if rsE != 0 && rsE == writeregM && regwriteM.
  - Otherwise 01 if rsE != 0 && rsE == writeregW && regwriteW.
  - Otherwise 00. M has priority over W. forwardBE uses the same rule with rtE.
  - forwardAD = rsD != 0 && rsD == writeregM && regwriteM. forwardBD uses the same rule with rtD.
- lwstall = memtoregE && (rtE == rsD || rtE == rtD).
- branchstall = branchD && ((regwriteE && writeregE ∈ {rsD, rtD}) || (memtoregM && writeregM ∈ {rsD, rtD})).
- memstall (below) freezes F, D, E and M together.
- Combinational outputs:
  - stallF = stallD = lwstall | branchstall | memstall.
  - stallE = stallM = memstall.
  - flushE = (lwstall | branchstall) & ~memstall.
  - flushD = (pcsrcD | jumpD) & ~stallD.
  - flushW = memstall, so W receives a bubble and does not retire the M instruction twice.
- Mem FSM (state register, async reset to IDLE):
  - IDLE: memstall = memreqM & ~dmem_ready. If memstall is high, go to WAIT and set waitcnt = 1.
  - WAIT: memstall = ~dmem_ready.
    - dmem_ready → IDLE. The stall drops in the same cycle ready is seen.
    - Else if waitcnt == TIMEOUT-1 → ERR.
    - Else waitcnt increments.
  - ERR: memstall = 1 unconditionally, dmem_err = 1. The only exit is reset. dmem_ready is ignored.
  - Back-to-back accesses: a ready in WAIT returns to IDLE. If the next M instruction also requests without ready, WAIT is re-entered the next cycle.
- stall_cycles increments each cycle stallF = 1 and saturates at all-ones (no wrap).
- Reset (reset = 0, asynchronous):
  - State goes to IDLE, waitcnt = 0, stall_cycles = 0, dmem_err = 0.
  - Combinational outputs then follow inputs with memstall = 0.
  - Reset mid-WAIT or in ERR aborts immediately.
  - After reset deassertion, the first active edge behaves as IDLE.
- Simultaneous events:
  - memstall suppresses flushE and flushD. The hazard is re-evaluated once memstall drops.
  - lwstall and branchstall together give a single stall, not additive.
  - Register 0 never forwards and never causes a forwarding match. The stall equations do not special-case register 0; a stall on $0 is harmless.

Test Plan:
- Load-use: memtoregE=1, rtE=5, rsD=5 → stallF=stallD=flushE=1, forwardAE=00. The next cycle, with the load in M (regwriteM=1, writeregM=5, rsE=5), forwardAE=10.
- Double write: regwriteM=regwriteW=1, writeregM=writeregW=3, rsE=3 → forwardAE=10. With writeregM=0 and rsE=0 → forwardAE=00.
- Branch hazard: branchD=1, regwriteE=1, writeregE=rtD=7 → stall 1 cycle. Then memtoregM=1, writeregM=7 → stall again. With pcsrcD=1 and no stall → flushD=1.
- Memory wait: memreqM=1, dmem_ready low for 3 cycles then high → stallE=stallM=flushW=1 for 3 cycles and 0 in the ready cycle, FSM back in IDLE, stall_cycles=3.
- Timeout with TIMEOUT=4: dmem_ready held low → ERR after 4 stalled cycles, dmem_err=1 stays high even when dmem_ready rises. Pulse reset=0 mid-cycle → dmem_err=0 and stalls clear asynchronously.
- Counter saturation with CNT_W=4: hold lwstall for 20 cycles → stall_cycles stops at 15.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: pipeline register specifiers and control bits in,
// stall/flush/forward selects and memory-wait status out.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rsD, rtD, rsE, rtE;
  logic [4:0]       writeregE, writeregM, writeregW;
  logic             regwriteE, regwriteM, regwriteW;
  logic             memtoregE, memtoregM;
  logic             branchD, jumpD, pcsrcD;
  logic             memreqM, dmem_ready;
  logic             stallF, stallD, stallE, stallM;
  logic             flushD, flushE, flushW;
  logic             forwardAD, forwardBD;
  logic [1:0]       forwardAE, forwardBE;
  logic             dmem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, jumpD, pcsrcD, memreqM, dmem_ready,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAD, forwardBD, forwardAE, forwardBE, dmem_err, stall_cycles
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, jumpD, pcsrcD, memreqM, dmem_ready,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAD, forwardBD, forwardAE, forwardBE, dmem_err, stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// 5-stage MIPS hazard/forwarding unit with a data-memory wait FSM (timeout
// to a sticky error state) and a saturating stall-cycle counter.
module hazard_fwd_lane (
  input  logic [4:0] srcE,
  input  logic [4:0] srcD,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteM,
  input  logic       regwriteW,
  output logic [1:0] fwdE,
  output logic       fwdD
);
  logic hitM, hitW;

  // $0 is hardwired zero, so it never forwards
  assign hitM = (srcE != 5'd0) && (srcE == writeregM) && regwriteM;
  assign hitW = (srcE != 5'd0) && (srcE == writeregW) && regwriteW;
  assign fwdE = hitM ? 2'b10 : (hitW ? 2'b01 : 2'b00);
  assign fwdD = (srcD != 5'd0) && (srcD == writeregM) && regwriteM;
endmodule

module hazard_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  hazard_unit_if.slave hz
);
  localparam int NUM_OPS = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [NUM_OPS-1:0][4:0] srcE, srcD;
  logic [NUM_OPS-1:0][1:0] fwdE;
  logic [NUM_OPS-1:0]      fwdD;

  logic [1:0]       state, state_n;
  logic [7:0]       waitcnt, waitcnt_n;
  logic             memstall_raw, memstall;
  logic             lwstall, branchstall, stall_fd;
  logic [CNT_W-1:0] cnt;

  // operand 0 = A (rs), operand 1 = B (rt)
  assign srcE = {hz.rtE, hz.rsE};
  assign srcD = {hz.rtD, hz.rsD};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    hazard_fwd_lane u_lane (
      .srcE      (srcE[i]),
      .srcD      (srcD[i]),
      .writeregM (hz.writeregM),
      .writeregW (hz.writeregW),
      .regwriteM (hz.regwriteM),
      .regwriteW (hz.regwriteW),
      .fwdE      (fwdE[i]),
      .fwdD      (fwdD[i])
    );
  end

  assign hz.forwardAE = fwdE[0];
  assign hz.forwardBE = fwdE[1];
  assign hz.forwardAD = fwdD[0];
  assign hz.forwardBD = fwdD[1];

  assign lwstall = hz.memtoregE && ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
  assign branchstall = hz.branchD &&
    ((hz.regwriteE && ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
     (hz.memtoregM && ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));

  always_comb begin
    state_n      = state;
    waitcnt_n    = waitcnt;
    memstall_raw = 1'b0;
    case (state)
      S_IDLE: begin
        memstall_raw = hz.memreqM & ~hz.dmem_ready;
        if (memstall_raw) begin
          state_n   = S_WAIT;
          waitcnt_n = 8'd1;
        end
      end
      S_WAIT: begin
        memstall_raw = ~hz.dmem_ready;
        if (hz.dmem_ready) begin
          state_n   = S_IDLE;
          waitcnt_n = 8'd0;
        end else if (waitcnt == 8'(TIMEOUT - 1)) begin
          state_n = S_ERR;
        end else begin
          waitcnt_n = waitcnt + 8'd1;
        end
      end
      S_ERR:   memstall_raw = 1'b1;
      default: state_n = S_IDLE;
    endcase
  end

  // Reset also masks the IDLE-state request term so stalls clear immediately
  assign memstall = memstall_raw & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      waitcnt <= 8'd0;
    end else begin
      state   <= state_n;
      waitcnt <= waitcnt_n;
    end
  end

  assign stall_fd   = lwstall | branchstall | memstall;
  assign hz.stallF  = stall_fd;
  assign hz.stallD  = stall_fd;
  assign hz.stallE  = memstall;
  assign hz.stallM  = memstall;
  assign hz.flushE  = (lwstall | branchstall) & ~memstall;
  assign hz.flushD  = (hz.pcsrcD | hz.jumpD) & ~stall_fd;
  // W takes a bubble while M is frozen so the M instruction retires once
  assign hz.flushW  = memstall;
  assign hz.dmem_err = (state == S_ERR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (stall_fd && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

  assign hz.stall_cycles = cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit built with TIMEOUT=4 and CNT_W=4.
module tb_hazard_unit;
  logic clk;
  logic reset;
  int   passed;
  int   total;

  hazard_unit_if #(.CNT_W(4)) hz ();

  hazard_unit #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    hz.rsD = 5'd0; hz.rtD = 5'd0; hz.rsE = 5'd0; hz.rtE = 5'd0;
    hz.writeregE = 5'd0; hz.writeregM = 5'd0; hz.writeregW = 5'd0;
    hz.regwriteE = 1'b0; hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
    hz.memtoregE = 1'b0; hz.memtoregM = 1'b0;
    hz.branchD = 1'b0; hz.jumpD = 1'b0; hz.pcsrcD = 1'b0;
    hz.memreqM = 1'b0; hz.dmem_ready = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    hz.memreqM = 1'b1;
    #1;
    total++;
    if (hz.stallF !== 1'b0 || hz.stallE !== 1'b0 || hz.flushW !== 1'b0) $display("FAIL reset_stalls stallF=%b stallE=%b flushW=%b required 0 0 0", hz.stallF, hz.stallE, hz.flushW); else passed++;
    total++;
    if (hz.dmem_err !== 1'b0 || hz.stall_cycles !== 4'd0) $display("FAIL reset_state dmem_err=%b stall_cycles=%0d required 0 0", hz.dmem_err, hz.stall_cycles); else passed++;
    hz.memreqM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    hz.memtoregE = 1'b1; hz.rtE = 5'd5; hz.rsD = 5'd5;
    #1;
    total++;
    if ({hz.stallF, hz.stallD, hz.flushE, hz.stallE} !== 4'b1110) $display("FAIL loaduse_stall stallF,D,flushE,stallE=%b required 1110", {hz.stallF, hz.stallD, hz.flushE, hz.stallE}); else passed++;
    total++;
    if (hz.forwardAE !== 2'b00) $display("FAIL loaduse_fwd0 forwardAE=%b required 00", hz.forwardAE); else passed++;
    @(negedge clk);
    clear_inputs();
    hz.regwriteM = 1'b1; hz.memtoregM = 1'b1; hz.writeregM = 5'd5; hz.rsE = 5'd5;
    #1;
    total++;
    if (hz.forwardAE !== 2'b10 || hz.stallF !== 1'b0) $display("FAIL loaduse_fwd1 forwardAE=%b stallF=%b required 10 0", hz.forwardAE, hz.stallF); else passed++;
  endtask

  task automatic test_forward();
    @(negedge clk);
    clear_inputs();
    hz.regwriteM = 1'b1; hz.regwriteW = 1'b1;
    hz.writeregM = 5'd3; hz.writeregW = 5'd3; hz.rsE = 5'd3; hz.rtE = 5'd3;
    #1;
    total++;
    if (hz.forwardAE !== 2'b10 || hz.forwardBE !== 2'b10) $display("FAIL fwd_mprio forwardAE=%b forwardBE=%b required 10 10", hz.forwardAE, hz.forwardBE); else passed++;
    hz.writeregM = 5'd4;
    #1;
    total++;
    if (hz.forwardAE !== 2'b01) $display("FAIL fwd_w forwardAE=%b required 01", hz.forwardAE); else passed++;
    hz.regwriteW = 1'b0;
    #1;
    total++;
    if (hz.forwardAE !== 2'b00) $display("FAIL fwd_nowrite forwardAE=%b required 00", hz.forwardAE); else passed++;
    hz.regwriteW = 1'b1; hz.writeregM = 5'd0; hz.writeregW = 5'd0; hz.rsE = 5'd0;
    #1;
    total++;
    if (hz.forwardAE !== 2'b00) $display("FAIL fwd_reg0 forwardAE=%b required 00", hz.forwardAE); else passed++;
    hz.writeregM = 5'd9; hz.rsD = 5'd9; hz.rtD = 5'd8;
    #1;
    total++;
    if ({hz.forwardAD, hz.forwardBD} !== 2'b10) $display("FAIL fwd_dec AD,BD=%b required 10", {hz.forwardAD, hz.forwardBD}); else passed++;
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    hz.branchD = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd7; hz.rtD = 5'd7; hz.rsD = 5'd1;
    hz.pcsrcD = 1'b1;
    #1;
    total++;
    if ({hz.stallF, hz.flushE, hz.flushD} !== 3'b110) $display("FAIL br_ealu stallF,flushE,flushD=%b required 110", {hz.stallF, hz.flushE, hz.flushD}); else passed++;
    @(negedge clk);
    hz.regwriteE = 1'b0; hz.writeregE = 5'd0;
    hz.memtoregM = 1'b1; hz.writeregM = 5'd7;
    #1;
    total++;
    if ({hz.stallF, hz.stallD, hz.flushE} !== 3'b111) $display("FAIL br_mload stallF,D,flushE=%b required 111", {hz.stallF, hz.stallD, hz.flushE}); else passed++;
    @(negedge clk);
    hz.memtoregM = 1'b0;
    #1;
    total++;
    if ({hz.stallF, hz.flushD} !== 2'b01) $display("FAIL br_taken stallF,flushD=%b required 01", {hz.stallF, hz.flushD}); else passed++;
    hz.pcsrcD = 1'b0; hz.branchD = 1'b0; hz.jumpD = 1'b1;
    #1;
    total++;
    if (hz.flushD !== 1'b1) $display("FAIL br_jump flushD=%b required 1", hz.flushD); else passed++;
    // load-use and branch hazard together: still a single stall
    hz.jumpD = 1'b0; hz.branchD = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd7;
    hz.memtoregE = 1'b1; hz.rtE = 5'd7;
    #1;
    total++;
    if ({hz.stallF, hz.flushE, hz.stallE} !== 3'b110) $display("FAIL br_plus_lw stallF,flushE,stallE=%b required 110", {hz.stallF, hz.flushE, hz.stallE}); else passed++;
  endtask

  task automatic test_mem_wait();
    reset_dut();
    hz.memreqM = 1'b1; hz.dmem_ready = 1'b0;
    // a pending hazard must not flush while memory holds the pipe
    hz.memtoregE = 1'b1; hz.rtE = 5'd2; hz.rsD = 5'd2; hz.pcsrcD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({hz.stallF, hz.stallE, hz.stallM, hz.flushW, hz.flushE, hz.flushD} !== 6'b111100) $display("FAIL memwait_c%0d stallF,E,M,flushW,E,D=%b required 111100", i, {hz.stallF, hz.stallE, hz.stallM, hz.flushW, hz.flushE, hz.flushD}); else passed++;
      @(negedge clk);
    end
    clear_inputs();
    hz.memreqM = 1'b1; hz.dmem_ready = 1'b1;
    #1;
    total++;
    if ({hz.stallF, hz.stallE, hz.stallM, hz.flushW} !== 4'b0000) $display("FAIL memwait_ready stallF,E,M,flushW=%b required 0000", {hz.stallF, hz.stallE, hz.stallM, hz.flushW}); else passed++;
    @(negedge clk);
    hz.memreqM = 1'b0; hz.dmem_ready = 1'b0;
    #1;
    total++;
    if (hz.stallE !== 1'b0 || hz.stall_cycles !== 4'd3) $display("FAIL memwait_idle stallE=%b stall_cycles=%0d required 0 3", hz.stallE, hz.stall_cycles); else passed++;
    // back-to-back: a new unready request re-enters WAIT
    hz.memreqM = 1'b1;
    @(negedge clk);
    hz.memreqM = 1'b0;
    #1;
    total++;
    if (hz.stallE !== 1'b1) $display("FAIL memwait_b2b stallE=%b required 1", hz.stallE); else passed++;
    hz.dmem_ready = 1'b1;
    @(negedge clk);
    hz.dmem_ready = 1'b0;
    #1;
    total++;
    if (hz.stallE !== 1'b0 || hz.stall_cycles !== 4'd4) $display("FAIL memwait_b2b_done stallE=%b stall_cycles=%0d required 0 4", hz.stallE, hz.stall_cycles); else passed++;
  endtask

  task automatic test_timeout();
    reset_dut();
    hz.memreqM = 1'b1; hz.dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (hz.dmem_err !== 1'b0 || hz.stallE !== 1'b1) $display("FAIL tmo_early dmem_err=%b stallE=%b required 0 1", hz.dmem_err, hz.stallE); else passed++;
    @(negedge clk);
    #1;
    total++;
    if (hz.dmem_err !== 1'b1) $display("FAIL tmo_err dmem_err=%b required 1", hz.dmem_err); else passed++;
    hz.dmem_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (hz.dmem_err !== 1'b1 || hz.stallE !== 1'b1 || hz.stallF !== 1'b1) $display("FAIL tmo_sticky dmem_err=%b stallE=%b stallF=%b required 1 1 1", hz.dmem_err, hz.stallE, hz.stallF); else passed++;
    hz.dmem_ready = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (hz.dmem_err !== 1'b0 || hz.stallE !== 1'b0 || hz.stallF !== 1'b0 || hz.stall_cycles !== 4'd0) $display("FAIL tmo_async_rst dmem_err=%b stallE=%b stallF=%b cycles=%0d required 0 0 0 0", hz.dmem_err, hz.stallE, hz.stallF, hz.stall_cycles); else passed++;
    hz.memreqM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    reset_dut();
    hz.memtoregE = 1'b1; hz.rtE = 5'd5; hz.rsD = 5'd5;
    repeat (14) @(negedge clk);
    #1;
    total++;
    if (hz.stall_cycles !== 4'd14) $display("FAIL sat_count stall_cycles=%0d required 14", hz.stall_cycles); else passed++;
    repeat (6) @(negedge clk);
    #1;
    total++;
    if (hz.stall_cycles !== 4'd15) $display("FAIL sat_hold stall_cycles=%0d required 15", hz.stall_cycles); else passed++;
    clear_inputs();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
